alu_multicycle_seq: RTL and testbench

- Sequencer for the ALU opcodes that have no single-cycle implementation: CLO/CLZ (12), SRL/ROTR (13) and SRA (15).
- Latches operands on Start, iterates one bit per clock over an internal working register, then presents a registered Result/Zero with a one-cycle Done pulse.
- Sits beside the single-cycle ALU in EX. Control muxes its Result into the writeback path and holds the pipeline while Busy is high.

---
 rtl/alu_multicycle_seq.sv | 99 +++++++++
 tb/tb_alu_multicycle_seq.sv | 94 +++++++++
 2 files changed

// File: rtl/alu_multicycle_seq.sv
// alu_multicycle_seq: bit-serial sequencer for the SRA, SRL/ROTR and CLO/CLZ ALU opcodes
module alu_multicycle_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);
  typedef enum logic [1:0] {IDLE, SHIFT, COUNT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d, result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic mode_q, mode_d, busy_q, busy_d, done_q, done_d, zero_q, zero_d;
  logic unused_b;
  assign unused_b = ^B[WIDTH-1:6];
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mode_d   = mode_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (Start) begin
        work_d = A;
        op_d   = ALUControl;
        mode_d = (ALUControl == 4'd12) ? B[0] : B[5];
        cnt_d  = (ALUControl == 4'd12) ? '0 : CNT_W'(B[4:0]);
        if (ALUControl == 4'd15 || ALUControl == 4'd13) begin
          state_d  = (B[4:0] == 5'd0) ? DONE : SHIFT;
          result_d = (B[4:0] == 5'd0) ? A : result_q;
        end else if (ALUControl == 4'd12) begin
          state_d = COUNT;
        end else begin
          state_d  = DONE;
          result_d = '0;
        end
      end
      SHIFT: begin
        work_d = {(op_q == 4'd15) ? work_q[WIDTH-1] : (mode_q & work_q[0]), work_q[WIDTH-1:1]};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          result_d = work_d;
        end
      end
      COUNT: begin
        if (work_q[WIDTH-1] == mode_q) begin
          cnt_d  = cnt_q + 1'b1;
          work_d = work_q << 1;
        end
        if (work_q[WIDTH-1] != mode_q || cnt_d == CNT_W'(WIDTH)) begin
          state_d  = DONE;
          result_d = WIDTH'(cnt_d);
        end
      end
      DONE: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT) || (state_d == COUNT);
    done_d = state_d == DONE;
    zero_d = result_d == '0;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      mode_q   <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
    end
  end
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;
  assign Zero   = zero_q;
endmodule

// File: tb/tb_alu_multicycle_seq.sv
// tb_alu_multicycle_seq: directed vectors with hand-computed cycle counts and results
module tb_alu_multicycle_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, busy, done, zero;
  logic [3:0] op = '0;
  logic [31:0] a = '0, b = '0, result;
  int total = 0, bad = 0;
  alu_multicycle_seq dut (
    .Clk(clk), .Reset(rst), .Start(start), .ALUControl(op), .A(a), .B(b),
    .Busy(busy), .Done(done), .Result(result), .Zero(zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                     input logic [3:0] top, input int exp_cyc, input logic [31:0] exp_res,
                     input int pulse, input bit restart);
    int cyc, bcnt;
    @(negedge clk);
    a = ta; b = tb; op = top; start = 1'b1;
    @(negedge clk);
    cyc = 1; bcnt = 0;
    while (1) begin
      if (cyc == pulse) begin
        a = 32'h1; b = 32'h1; op = 4'd13; start = 1'b1;
      end else start = 1'b0;
      if (done || cyc >= 40) break;
      bcnt += int'(busy);
      @(negedge clk);
      cyc++;
    end
    chk({tag, " done_cycle"}, done ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_cyc));
    chk({tag, " busy_cycles"}, 32'(bcnt), 32'(exp_cyc - 1));
    chk({tag, " result"}, result, exp_res);
    chk({tag, " zero"}, 32'(zero), 32'(exp_res == 32'h0));
    chk({tag, " busy_in_done"}, 32'(busy), 32'h0);
    start = restart;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done_pulse"}, 32'(done), 32'h0);
    if (restart) begin
      @(negedge clk);
      chk({tag, " no_second_done"}, 32'(done), 32'h0);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset result", result, 32'h0);
    chk("reset zero", 32'(zero), 32'h1);
    rst = 1'b0;
    run("sra4", 32'h8000_0010, 32'd4, 4'd15, 5, 32'hF800_0001, 0, 1'b0);
    run("rotr1", 32'h0000_0001, 32'h21, 4'd13, 2, 32'h8000_0000, 0, 1'b0);
    run("rotr4", 32'h1234_5678, 32'h24, 4'd13, 5, 32'h8123_4567, 0, 1'b0);
    run("srl31", 32'h8000_0000, 32'd31, 4'd13, 32, 32'h0000_0001, 0, 1'b0);
    run("srl4", 32'hF000_0000, 32'd4, 4'd13, 5, 32'h0F00_0000, 0, 1'b0);
    run("sra4neg", 32'hF000_0000, 32'd4, 4'd15, 5, 32'hFF00_0000, 0, 1'b0);
    run("shift0", 32'h0000_1234, 32'd0, 4'd13, 1, 32'h0000_1234, 0, 1'b0);
    run("clz15", 32'h0001_0000, 32'd0, 4'd12, 17, 32'd15, 0, 1'b0);
    run("clz32", 32'h0000_0000, 32'd0, 4'd12, 33, 32'd32, 0, 1'b0);
    run("clo0", 32'h7FFF_FFFF, 32'd1, 4'd12, 2, 32'd0, 0, 1'b0);
    run("clo32", 32'hFFFF_FFFF, 32'd1, 4'd12, 33, 32'd32, 0, 1'b0);
    run("illegal", 32'hDEAD_BEEF, 32'd3, 4'd2, 1, 32'h0, 0, 1'b1);
    run("busy_start", 32'h8000_0000, 32'd8, 4'd15, 9, 32'hFF80_0000, 3, 1'b0);
    @(negedge clk);
    a = 32'hF000_0000; b = 32'd20; op = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", 32'(busy), 32'h0);
    chk("midrst done", 32'(done), 32'h0);
    chk("midrst result", result, 32'h0);
    chk("midrst zero", 32'(zero), 32'h1);
    begin
      int seen = 0;
      repeat (25) begin
        @(negedge clk);
        seen += int'(done) + int'(busy);
      end
      chk("midrst quiet", 32'(seen), 32'h0);
    end
    run("after_rst", 32'h8000_0010, 32'd4, 4'd15, 5, 32'hF800_0001, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
